// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer between MEM stage and data-memory bus
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ld_data_align,
  output logic [1:0]  ld_addr_lsb,
  output logic [1:0]  ld_size,
  output logic        ld_en,
  output logic        rsp_valid,
  output logic        rsp_except,
  output logic        rsp_buserr
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Counter value on the last cycle a missing ack is tolerated.
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic            TO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic [1:0]        ld_lsb_q, ld_lsb_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_en_q, ld_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_except_q, rsp_except_d;
  logic              rsp_buserr_q, rsp_buserr_d;

  logic              misaligned;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata_rep;

  // Alignment check and lane steering of the incoming request.
  always_comb begin
    misaligned    = 1'b0;
    req_be        = 4'b0000;
    req_wdata_rep = 32'h0;
    case (req_size)
      SZ_BYTE: begin
        req_be        = 4'b0001 << req_addr[1:0];
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        misaligned    = req_addr[0];
        req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        misaligned    = (req_addr[1:0] != 2'b00);
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
      end
      default: begin
        misaligned    = 1'b1;
      end
    endcase
  end

  // Next-state and registered-output decode; response flags are set on entry to RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    ld_data_d    = ld_data_q;
    ld_lsb_d     = ld_lsb_q;
    ld_size_d    = ld_size_q;
    ld_en_d      = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_except_d = 1'b0;
    rsp_buserr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          ld_lsb_d  = req_addr[1:0];
          ld_size_d = req_size;
          cnt_d     = '0;
          if (misaligned) begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_except_d = 1'b1;
          end else begin
            state_d     = S_WAIT;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_be_d    = req_be;
            bus_wdata_d = req_we ? req_wdata_rep : 32'h0;
          end
        end
      end
      S_WAIT: begin
        if (bus_ack) begin
          // An ack on the expiry cycle takes priority over the timeout.
          state_d     = S_RESP;
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          ld_en_d     = ~we_q;
          if (!we_q) begin
            ld_data_d = bus_rdata;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d      = S_RESP;
          bus_req_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_buserr_d = 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight bus transaction.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_be_q     <= 4'b0000;
      bus_wdata_q  <= 32'h0;
      ld_data_q    <= 32'h0;
      ld_lsb_q     <= 2'b00;
      ld_size_q    <= 2'b00;
      ld_en_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_except_q <= 1'b0;
      rsp_buserr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      ld_data_q    <= ld_data_d;
      ld_lsb_q     <= ld_lsb_d;
      ld_size_q    <= ld_size_d;
      ld_en_q      <= ld_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_except_q <= rsp_except_d;
      rsp_buserr_q <= rsp_buserr_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;
  assign ld_data_align = ld_data_q;
  assign ld_addr_lsb   = ld_lsb_q;
  assign ld_size       = ld_size_q;
  assign ld_en         = ld_en_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_except    = rsp_except_q;
  assign rsp_buserr    = rsp_buserr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [31:0] ld_data_align;
  logic [1:0]  ld_addr_lsb, ld_size;
  logic        ld_en, rsp_valid, rsp_except, rsp_buserr;

  mem_access_ctrl #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .ld_data_align(ld_data_align), .ld_addr_lsb(ld_addr_lsb), .ld_size(ld_size),
    .ld_en(ld_en), .rsp_valid(rsp_valid), .rsp_except(rsp_except), .rsp_buserr(rsp_buserr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        except;
    logic        buserr;
    logic        ld_en;
    logic [31:0] data;
    logic [1:0]  lsb;
    logic [1:0]  size;
  } rsp_t;

  rsp_t exp_q[$];
  int   rsp_cyc[$];
  rsp_t exp_mon;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    if (rst_b) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_mon = exp_q.pop_front();
          chk("rsp_except", {31'd0, rsp_except}, {31'd0, exp_mon.except});
          chk("rsp_buserr", {31'd0, rsp_buserr}, {31'd0, exp_mon.buserr});
          chk("ld_en", {31'd0, ld_en}, {31'd0, exp_mon.ld_en});
          if (exp_mon.ld_en) begin
            chk("ld_data", ld_data_align, exp_mon.data);
            chk("ld_lsb", {30'd0, ld_addr_lsb}, {30'd0, exp_mon.lsb});
            chk("ld_size", {30'd0, ld_size}, {30'd0, exp_mon.size});
          end
          rsp_cyc.push_back(cyc);
        end
      end else if (ld_en) begin
        chk("ld_en_alone", {31'd0, ld_en}, 32'd0);
      end
    end
  end

  // One request: ack_cyc is the cycle (after accept) carrying bus_ack, 0 for none.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input int ack_cyc, input logic [31:0] rdata,
                        input logic [3:0] xbe, input logic [31:0] xwd);
    rsp_t e;
    logic mis;
    int   end_cyc;
    mis = (size == 2'b10) || (size == 2'b01 && addr[0]) || (size == 2'b11 && addr[1:0] != 2'b00);
    end_cyc  = mis ? 0 : ((ack_cyc == 0) ? TO : ack_cyc);
    e.except = mis;
    e.buserr = !mis && (ack_cyc == 0);
    e.ld_en  = !we && !mis && (ack_cyc != 0);
    e.data   = rdata;
    e.lsb    = addr[1:0];
    e.size   = size;
    exp_q.push_back(e);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= end_cyc; c++) begin
      chk("bus_req_held", {31'd0, bus_req}, 32'd1);
      chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      if (c == 1) begin
        chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
        chk("bus_be", {28'd0, bus_be}, {28'd0, xbe});
        chk("bus_we", {31'd0, bus_we}, {31'd0, we});
        chk("bus_wdata", bus_wdata, xwd);
      end
      if (c == ack_cyc) begin
        bus_ack = 1'b1; bus_rdata = rdata;
      end
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = 32'h0;
    end
    chk("rsp_on_time", {31'd0, rsp_valid}, 32'd1);
    chk("bus_req_off", {31'd0, bus_req}, 32'd0);
    chk("req_ready_resp", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("ld_en_one_cycle", {31'd0, ld_en}, 32'd0);
  endtask

  int n;

  initial begin
    rst_b = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'b00; req_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ld_en", {31'd0, ld_en}, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_ld_data", ld_data_align, 32'd0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // Load byte at 0x1003, ack at cycle 2.
    do_req(1'b0, 32'h1003, 2'b00, 32'h0, 2, 32'hA1B2C3D4, 4'b1000, 32'h0);
    // Store half at 0x2002, ack on cycle 4.
    do_req(1'b1, 32'h2002, 2'b01, 32'h0000BEEF, 4, 32'h0, 4'b1100, 32'hBEEFBEEF);
    // Misaligned / illegal.
    do_req(1'b0, 32'h3001, 2'b11, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
    do_req(1'b1, 32'h3001, 2'b01, 32'h1234, 1, 32'h0, 4'b0000, 32'h0);
    do_req(1'b0, 32'h3000, 2'b10, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
    // Timeout, then ack exactly on the expiry cycle.
    do_req(1'b0, 32'h0500, 2'b11, 32'h0, 0, 32'h0, 4'b1111, 32'h0);
    do_req(1'b0, 32'h0504, 2'b11, 32'h0, TO, 32'h12345678, 4'b1111, 32'h0);
    // Extra lane patterns.
    do_req(1'b1, 32'h0007, 2'b00, 32'hFFFFFF5A, 3, 32'h0, 4'b1000, 32'h5A5A5A5A);
    do_req(1'b0, 32'h0006, 2'b01, 32'h0, 1, 32'h87654321, 4'b1100, 32'h0);
    do_req(1'b1, 32'h0000, 2'b01, 32'h1111CDEF, 2, 32'h0, 4'b0011, 32'hCDEFCDEF);

    // Reset in the middle of WAIT.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_size = 2'b11;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw_bus_req_c1", {31'd0, bus_req}, 32'd1);
    @(negedge clk);
    chk("rstw_bus_req_c2", {31'd0, bus_req}, 32'd1);
    rst_b = 1'b0;
    #1;
    chk("rstw_async_drop", {31'd0, bus_req}, 32'd0);
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_no_rsp", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    bus_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstw_idle_ready", {31'd0, req_ready}, 32'd1);
      chk("rstw_idle_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("ack_ignored_idle", {31'd0, bus_req}, 32'd0);
    end
    bus_ack = 1'b0;
    do_req(1'b0, 32'h0044, 2'b11, 32'h0, 1, 32'h55AA55AA, 4'b1111, 32'h0);

    // Back-to-back zero-wait accesses.
    n = rsp_cyc.size();
    do_req(1'b0, 32'h0000, 2'b11, 32'h0, 1, 32'hCAFEF00D, 4'b1111, 32'h0);
    do_req(1'b1, 32'h0004, 2'b11, 32'h11223344, 1, 32'h0, 4'b1111, 32'h11223344);
    if (rsp_cyc.size() >= n + 2)
      chk("b2b_spacing", rsp_cyc[n+1] - rsp_cyc[n], 32'd3);
    else
      chk("b2b_rsp_count", rsp_cyc.size() - n, 32'd2);

    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer between the MEM pipeline stage and the data-memory bus; the read-data aligner sits directly downstream of it.
- Accepts one load/store request at a time and checks alignment before issuing anything.
- Drives a word-aligned bus transaction with byte enables and replicated store data.
- Captures the raw load word and presents it, with addr_lsb and size, to the read aligner, then returns a completion or exception response.

Parameters:
- TIMEOUT, 255: max cycles waiting for bus_ack before bus error; 0 disables the timeout.
- TO_W, 8: timeout counter width; requires TIMEOUT < 2**TO_W.

Ports:
- clk  input  1  clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_we  input  1  1=store, 0=load
- req_addr  input  32  byte address
- req_size  input  2  memsize_s: BYTE=2'b00, HALF=2'b01, WORD=2'b11; 2'b10 illegal
- req_wdata  input  32  store data, right-justified
- bus_req  output  1  bus transaction request, held until ack
- bus_we  output  1  bus write
- bus_addr  output  32  {req_addr[31:2],2'b00}
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-replicated store data
- bus_ack  input  1  transaction complete; bus_rdata valid this cycle for reads
- bus_rdata  input  32  raw read word
- ld_data_align  output  32  captured raw word, to aligner data_align
- ld_addr_lsb  output  2  captured req_addr[1:0], to aligner addr_lsb
- ld_size  output  2  captured req_size, to aligner size
- ld_en  output  1  aligner enable, one-cycle pulse
- rsp_valid  output  1  completion pulse, one cycle
- rsp_except  output  1  misalign or illegal size; qualifies rsp_valid
- rsp_buserr  output  1  bus timeout; qualifies rsp_valid

Behaviour:
- Reset (async, rst_b=0): state IDLE; every output 0 except req_ready=1; timeout counter 0. If asserted mid-transaction, bus_req drops immediately and the transaction is abandoned with no response.
- All outputs are registered except req_ready, which is decoded from state.
- States: IDLE, WAIT, RESP.
- IDLE, req_valid=1: capture we, addr, size, wdata. Misaligned if size=HALF with addr[0]=1, size=WORD with addr[1:0]!=0, or size=2'b10.
  - Misaligned: go to RESP with rsp_except=1; bus_req stays 0.
  - Otherwise: go to WAIT; bus_req=1 from the next cycle.
- Byte enables and write data:
  - BYTE: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - HALF: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - WORD: be = 4'b1111; wdata unchanged.
  - Loads drive the same be (informational); bus_wdata=0.
- WAIT:
  - bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable until ack. The timeout counter increments each cycle without ack.
  - bus_ack=1: for loads, ld_data_align <= bus_rdata. Drop bus_req next cycle; go to RESP.
  - Counter reaches TIMEOUT with no ack (TIMEOUT!=0): drop bus_req; go to RESP with rsp_buserr=1. An ack in the same cycle as expiry wins, and no error is raised.
- RESP, one cycle:
  - rsp_valid=1.
  - ld_en=1 only for a load with no except or buserr.
  - ld_addr_lsb and ld_size are valid the whole time ld_en=1.
  - Return to IDLE; counter cleared; rsp_* and ld_en return to 0.
- ld_data_align, ld_addr_lsb and ld_size hold their last values until the next capture.
- Latency:
  - Request accepted at cycle 0; bus_req high at cycle 1.
  - Ack at cycle k gives rsp_valid at cycle k+1.
  - Zero-wait bus (ack at cycle 1) gives rsp at cycle 2.
  - Misaligned request gives rsp at cycle 1.
- Back-to-back: a new request can be accepted at the cycle after RESP, so throughput is one access per 3 cycles minimum.
- bus_ack outside WAIT is ignored. req_valid outside IDLE is ignored; the requester holds it.

Test Plan:
- Load byte: addr=0x1003, BYTE; bus_ack at cycle 2 with rdata=0xA1B2C3D4. Expect bus_addr=0x1000, be=4'b1000, bus_we=0. At cycle 3: rsp_valid=1, ld_en=1, ld_data_align=0xA1B2C3D4, ld_addr_lsb=3, ld_size=BYTE.
- Store half: addr=0x2002, HALF, wdata=0x0000BEEF. Expect bus_be=4'b1100, bus_wdata=0xBEEFBEEF, bus_we=1. bus_req is held 4 cycles until ack; rsp_valid=1, ld_en=0.
- Misaligned: WORD at 0x3001, then HALF at 0x3001, then size 2'b10. Each gives rsp_valid=rsp_except=1 at cycle 1, bus_req never asserted, ld_en=0.
- Timeout: TIMEOUT=4, load with no ack. Expect bus_req high exactly 4 cycles, then rsp_valid=rsp_buserr=1, ld_en=0. Repeat with ack on the expiry cycle: expect normal completion, buserr=0.
- Reset mid-WAIT: rst_b=0 while bus_req=1. Expect bus_req=0 asynchronously, no rsp_valid, req_ready=1 after release, and the next request completes normally.
- Back-to-back: word load 0x0 then word store 0x4 with zero-wait ack. Expect rsp at cycles 2 and 5, req_ready low in cycles 1-2 and 4-5.
